// File: rtl/matrix_result_serializer.sv
// Captures a completed result matrix on a rising done_in and streams it out
// as little-endian byte triplets over a valid/ready handshake.
module matrix_result_serializer #(
  parameter int NUM_ELEMS = 9,
  parameter int ELEM_W    = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done_in,
  input  logic [ELEM_W-1:0] C [0:NUM_ELEMS-1],
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        frames_sent
);
  localparam int IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            state_reg, state_next;
  logic              done_prev_reg;
  logic [IDX_W-1:0]  elem_idx_reg;
  logic [1:0]        byte_idx_reg;
  logic [ELEM_W-1:0] buffer_reg [0:NUM_ELEMS-1];
  logic              overrun_reg;
  logic [7:0]        frames_sent_reg;

  logic              capture;
  logic              start;
  logic              transfer;
  logic              final_byte;
  logic [23:0]       elem_ext;

  assign capture    = done_in & ~done_prev_reg;
  assign start      = (state_reg == IDLE) && capture;
  assign transfer   = out_valid & out_ready;
  assign final_byte = (elem_idx_reg == IDX_W'(NUM_ELEMS - 1)) && (byte_idx_reg == 2'd2);
  // Zero-extend so the third byte carries only the element's upper bits.
  assign elem_ext   = 24'(buffer_reg[elem_idx_reg]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == IDLE) begin
      if (capture) state_next = SEND;
    end else begin
      if (transfer && final_byte) state_next = IDLE;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 8'd0;
    busy      = 1'b0;
    if (state_reg == SEND) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_last  = final_byte;
      case (byte_idx_reg)
        2'd0:    out_data = elem_ext[7:0];
        2'd1:    out_data = elem_ext[15:8];
        default: out_data = elem_ext[23:16];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_prev_reg   <= 1'b0;
      elem_idx_reg    <= '0;
      byte_idx_reg    <= '0;
      overrun_reg     <= 1'b0;
      frames_sent_reg <= 8'd0;
    end else begin
      done_prev_reg <= done_in;
      // A new result while streaming is dropped, the current frame keeps going.
      if ((state_reg == SEND) && capture) overrun_reg <= 1'b1;
      if (start) begin
        elem_idx_reg <= '0;
        byte_idx_reg <= '0;
      end else if (transfer) begin
        if (byte_idx_reg == 2'd2) begin
          byte_idx_reg <= '0;
          if (final_byte) begin
            elem_idx_reg    <= '0;
            frames_sent_reg <= frames_sent_reg + 8'd1;
          end else begin
            elem_idx_reg <= elem_idx_reg + IDX_W'(1);
          end
        end else begin
          byte_idx_reg <= byte_idx_reg + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ELEMS; i++) begin
      if (reset) begin
        buffer_reg[i] <= '0;
      end else if (start) begin
        buffer_reg[i] <= C[i];
      end
    end
  end

  assign overrun     = overrun_reg;
  assign frames_sent = frames_sent_reg;

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench for matrix_result_serializer: frames, backpressure, overrun,
// mid-frame reset and frame-counter wrap.
module tb_matrix_result_serializer;
  typedef logic [17:0] mat_t [0:8];

  logic       clk;
  logic       reset;
  logic       done_in;
  mat_t       c;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       overrun;
  logic [7:0] frames_sent;

  mat_t       c1, c2, c3, exp_m;
  logic [7:0] fs_exp;
  int         n_cmp;
  int         n_err;

  matrix_result_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .done_in    (done_in),
    .C          (c),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .overrun    (overrun),
    .frames_sent(frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    logic [17:0] e;
    e = exp_m[k / 3];
    case (k % 3)
      0:       return e[7:0];
      1:       return e[15:8];
      default: return {6'b0, e[17:16]};
    endcase
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_data"}, out_data, 0);
  endtask

  // Entered one sample after the capture edge; expects exactly 27 transfers.
  task automatic run_frame(input int stall_at, input int glitch_at);
    for (int k = 0; k < 27; k++) begin
      if (k == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, exp_byte(k));
          check("stall_last", out_last, 0);
          tick();
        end
        out_ready = 1'b1;
      end
      if (k == glitch_at) begin
        done_in = 1'b1;
        c = c3;
      end
      check($sformatf("valid_b%0d", k), out_valid, 1);
      check($sformatf("data_b%0d", k), out_data, exp_byte(k));
      check($sformatf("last_b%0d", k), out_last, (k == 26) ? 1 : 0);
      check($sformatf("busy_b%0d", k), busy, 1);
      tick();
      if (k == glitch_at) done_in = 1'b0;
    end
    check_idle("frame_end");
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    fs_exp    = 8'd0;
    c1 = '{18'd30, 18'd24, 18'd18, 18'd84, 18'd69, 18'd54, 18'd138, 18'd114, 18'd90};
    c2 = '{default: 18'h2FA03};
    c3 = '{18'h3FFFF, 18'h12345, 18'h0ABCD, 18'h11111, 18'h22222, 18'h33333, 18'h00F0F, 18'h1F0F0, 18'h2AAAA};
    reset     = 1'b1;
    done_in   = 1'b0;
    out_ready = 1'b1;
    c         = c1;

    tick();
    tick();
    reset = 1'b0;
    check_idle("reset");
    check("reset_overrun", overrun, 0);
    check("reset_frames", frames_sent, 0);

    // Basic frame; done_in stays high afterwards and must not retrigger.
    exp_m   = c1;
    done_in = 1'b1;
    tick();
    check("first_byte", out_data, 8'h1E);
    run_frame(-1, -1);
    fs_exp++;
    check("frames_1", frames_sent, fs_exp);
    tick();
    tick();
    check_idle("level_high");
    check("level_overrun", overrun, 0);
    done_in = 1'b0;
    tick();

    // All elements 0x2FA03.
    c       = c2;
    exp_m   = c2;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    run_frame(-1, -1);
    fs_exp++;
    check("frames_2", frames_sent, fs_exp);

    // Backpressure on byte 1 of element 0.
    c       = c1;
    exp_m   = c1;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    run_frame(1, -1);
    fs_exp++;
    check("frames_3", frames_sent, fs_exp);

    // New result mid-frame with different C: dropped, sticky overrun.
    c       = c1;
    exp_m   = c1;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    run_frame(-1, 10);
    fs_exp++;
    check("frames_4", frames_sent, fs_exp);
    check("overrun_set", overrun, 1);
    tick();
    tick();
    check_idle("after_overrun");
    check("overrun_sticky", overrun, 1);
    check("frames_4_hold", frames_sent, fs_exp);

    // Reset after 4 transfers, with a capture edge in the reset cycle.
    c       = c1;
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("pre_reset_valid", out_valid, 1);
    reset   = 1'b1;
    done_in = 1'b1;
    tick();
    check_idle("mid_reset");
    check("mid_reset_frames", frames_sent, 0);
    check("mid_reset_overrun", overrun, 0);
    fs_exp  = 8'd0;
    c       = c2;
    exp_m   = c2;
    reset   = 1'b0;
    tick();
    done_in = 1'b0;
    check("restart_valid", out_valid, 1);
    check("restart_data", out_data, 8'h03);
    run_frame(-1, -1);
    fs_exp++;
    check("frames_restart", frames_sent, fs_exp);

    // 256 frames back to back: counter wraps to its starting value.
    c     = c1;
    exp_m = c1;
    for (int f = 0; f < 256; f++) begin
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      run_frame(-1, -1);
      fs_exp++;
      check($sformatf("frames_wrap_%0d", f), frames_sent, fs_exp);
      if (f == 254) check("frames_zero", frames_sent, 0);
    end
    check("frames_final", frames_sent, 1);
    check("final_overrun", overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
